pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and return-address-stack unit for the 4-bit-opcode core.
//  Consumes the decoder's jump_en/branch_en/call_en/ret_en flags and produces
//  the fetch PC each cycle. Generates the sticky program_end that gates the
//  decoder. Ends the program on HALT opcode, stack fault or PC overrun.
// PARAMETERS
//  PC_W        8        PC / target address width
//  STACK_DEPTH 8        return-address stack entries (power of 2, >=2)
//  HALT_OP     4'b1111  opcode that terminates the program
// PORTS
//  clk             in   1        rising-edge clock
//  rst             in   1        asynchronous active-high reset
//  stall           in   1        hold PC/stack (accelerator or memory busy)
//  opcode          in   4        opcode of instruction at current pc
//  jump_en         in   1        unconditional jump this cycle
//  branch_en       in   1        conditional branch this cycle
//  branch_taken    in   1        ALU compare result, qualifies branch_en
//  call_en         in   1        call: push return addr, go to target
//  ret_en          in   1        return: pop stack into pc
//  target          in   PC_W     jump/branch/call destination
//  pc              out  PC_W     current fetch address (registered)
//  program_end     out  1        sticky end-of-program (registered)
//  stack_depth     out  clog2(STACK_DEPTH)+1  entries in use
//  stack_overflow  out  1        sticky: call with stack full
//  stack_underflow out  1        sticky: ret with stack empty
// BEHAVIOUR
//  Reset (async, any time, incl. mid-call): pc=0, program_end=0, stack_depth=0,
//   stack_overflow=0, stack_underflow=0. Stack contents don't-care.
//  Registered single-cycle update. Decision made on inputs at edge N.
//   Result is visible on pc after edge N. No combinational input->output path.
//  program_end=1 freezes pc, stack and flags. Only rst clears it.
//  stall=1 (program_end=0) holds all state, ignores all other inputs.
//  Otherwise evaluate in strict priority (first match wins):
//   1. opcode==HALT_OP -> program_end<=1, pc held.
//   2. ret_en: depth==0 -> stack_underflow<=1, program_end<=1, pc held.
//      else pc<=stack[depth-1], depth<=depth-1.
//   3. call_en: depth==STACK_DEPTH -> stack_overflow<=1, program_end<=1, pc held.
//      else stack[depth]<=pc+1 (PC_W wrap), depth<=depth+1, pc<=target.
//   4. jump_en -> pc<=target.
//   5. branch_en & branch_taken -> pc<=target.
//      branch_en & !branch_taken -> sequential.
//   6. sequential: pc=={PC_W{1'b1}} -> program_end<=1, pc held (no wrap to 0).
//      else pc<=pc+1.
//  Several enables high together is legal. Only the highest priority acts.
//  Call to own address / target==pc is legal (tight loop).
//  Push stores pc+1 truncated to PC_W. Call at max pc pushes 0 and is not an error.
//  Stack is LIFO, indexed by depth. No reads/writes when depth/flags forbid.
// TESTING
//  rst, 5 idle cycles -> pc 0,1,2,3,4,5; program_end=0; depth=0.
//  pc=3, call_en target=0x40 -> pc=0x40, depth=1. Later ret_en -> pc=4, depth=0.
//  9 nested calls (DEPTH=8) -> 9th sets stack_overflow=1, program_end=1,
//   pc stays at 8th target. Further inputs ignored.
//  ret_en at depth 0 -> stack_underflow=1, program_end=1.
//   Assert rst -> all outputs 0 immediately (async).
//  Same cycle ret_en+call_en+jump_en with depth=1 (top=0x11) -> pc=0x11.
//   Branch with taken=0 -> pc+1. stall=1 for 3 cycles -> pc constant.
//  opcode=HALT_OP at pc=7 -> program_end=1, pc=7 held. pc=0xFF sequential -> program_end=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter plus return-address stack; single-cycle registered update.
// Any fault (HALT, stack over/underflow, PC overrun) latches program_end until reset.
module pc_sequencer #(
  parameter int         PC_W        = 8,
  parameter int         STACK_DEPTH = 8,
  parameter logic [3:0] HALT_OP     = 4'b1111
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [3:0]                   opcode,
  input  logic                         jump_en,
  input  logic                         branch_en,
  input  logic                         branch_taken,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              pc,
  output logic                         program_end,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0]   DEPTH_FULL = DW'(STACK_DEPTH);
  localparam logic [DW-1:0]   DEPTH_ONE  = DW'(1);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
  localparam logic [PC_W-1:0] PC_MAX     = {PC_W{1'b1}};

  logic [PC_W-1:0] stack [STACK_DEPTH];

  logic [PC_W-1:0] pc_next;
  logic [DW-1:0]   depth_next;
  logic            end_next;
  logic            ovf_next;
  logic            unf_next;
  logic            push;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   push_idx;
  logic [PC_W-1:0] pc_inc;

  // Index wraps naturally; only used when depth guards allow the access.
  assign push_idx = stack_depth[AW-1:0];
  assign top_idx  = stack_depth[AW-1:0] - AW'(1);
  assign pc_inc   = pc + PC_ONE;

  always_comb begin
    pc_next    = pc;
    depth_next = stack_depth;
    end_next   = program_end;
    ovf_next   = stack_overflow;
    unf_next   = stack_underflow;
    push       = 1'b0;
    if (!program_end && !stall) begin
      if (opcode == HALT_OP) begin
        end_next = 1'b1;
      end else if (ret_en) begin
        if (stack_depth == '0) begin
          unf_next = 1'b1;
          end_next = 1'b1;
        end else begin
          pc_next    = stack[top_idx];
          depth_next = stack_depth - DEPTH_ONE;
        end
      end else if (call_en) begin
        if (stack_depth == DEPTH_FULL) begin
          ovf_next = 1'b1;
          end_next = 1'b1;
        end else begin
          push       = 1'b1;
          pc_next    = target;
          depth_next = stack_depth + DEPTH_ONE;
        end
      end else if (jump_en || (branch_en && branch_taken)) begin
        pc_next = target;
      end else if (pc == PC_MAX) begin
        // Running off the end of program memory stops rather than wrapping to 0.
        end_next = 1'b1;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= '0;
      stack_depth     <= '0;
      program_end     <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc              <= pc_next;
      stack_depth     <= depth_next;
      program_end     <= end_next;
      stack_overflow  <= ovf_next;
      stack_underflow <= unf_next;
    end
  end

  // Stack contents need no reset; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations queued per step, checked after each edge.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] opcode;
  logic       jump_en;
  logic       branch_en;
  logic       branch_taken;
  logic       call_en;
  logic       ret_en;
  logic [7:0] target;
  logic [7:0] pc;
  logic       program_end;
  logic [3:0] stack_depth;
  logic       stack_overflow;
  logic       stack_underflow;

  typedef struct packed {
    logic [7:0] pc;
    logic       pe;
    logic [3:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  pc_sequencer #(.PC_W(8), .STACK_DEPTH(8), .HALT_OP(4'b1111)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .opcode         (opcode),
    .jump_en        (jump_en),
    .branch_en      (branch_en),
    .branch_taken   (branch_taken),
    .call_en        (call_en),
    .ret_en         (ret_en),
    .target         (target),
    .pc             (pc),
    .program_end    (program_end),
    .stack_depth    (stack_depth),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic expect_state(input logic [7:0] p, input logic e, input logic [3:0] d,
                              input logic ov, input logic un);
    exp_t x;
    x = '{pc: p, pe: e, depth: d, ovf: ov, unf: un};
    sb.push_back(x);
  endtask

  task automatic compare(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s: scoreboard empty, observed pc %0h expected an entry", tag, pc);
    end else begin
      x = sb.pop_front();
      chk({tag, ".pc"},    32'(pc),              32'(x.pc));
      chk({tag, ".end"},   32'(program_end),     32'(x.pe));
      chk({tag, ".depth"}, 32'(stack_depth),     32'(x.depth));
      chk({tag, ".ovf"},   32'(stack_overflow),  32'(x.ovf));
      chk({tag, ".unf"},   32'(stack_underflow), 32'(x.unf));
    end
  endtask

  task automatic idle();
    stall = 0; opcode = 4'h0; jump_en = 0; branch_en = 0; branch_taken = 0;
    call_en = 0; ret_en = 0; target = 8'h00;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Asserted between edges so the zero check proves the reset is asynchronous.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    expect_state(8'h00, 0, 4'd0, 0, 0);
    compare(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    expect_state(8'h00, 0, 4'd0, 0, 0);
    compare("reset");
    rst = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      expect_state(8'(i), 0, 4'd0, 0, 0);
      tick("idle_seq");
    end

    // Call from pc=3 and return to 4.
    do_reset("reset2");
    for (int i = 1; i <= 3; i++) begin
      expect_state(8'(i), 0, 4'd0, 0, 0);
      tick("to_pc3");
    end
    idle(); call_en = 1; target = 8'h40;
    expect_state(8'h40, 0, 4'd1, 0, 0); tick("call40");
    idle();
    expect_state(8'h41, 0, 4'd1, 0, 0); tick("in_sub");
    idle(); ret_en = 1;
    expect_state(8'h04, 0, 4'd0, 0, 0); tick("ret_to4");

    idle(); branch_en = 1; branch_taken = 0; target = 8'h80;
    expect_state(8'h05, 0, 4'd0, 0, 0); tick("branch_nt");
    idle(); branch_en = 1; branch_taken = 1; target = 8'h80;
    expect_state(8'h80, 0, 4'd0, 0, 0); tick("branch_t");
    idle(); jump_en = 1; target = 8'h10;
    expect_state(8'h10, 0, 4'd0, 0, 0); tick("jump10");
    idle(); call_en = 1; target = 8'h50;
    expect_state(8'h50, 0, 4'd1, 0, 0); tick("call50");

    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; jump_en = 1; call_en = 1; target = 8'h99;
      expect_state(8'h50, 0, 4'd1, 0, 0); tick("stall");
    end

    idle(); ret_en = 1; call_en = 1; jump_en = 1; target = 8'h60;
    expect_state(8'h11, 0, 4'd0, 0, 0); tick("prio_ret");
    idle(); jump_en = 1; target = 8'h11;
    expect_state(8'h11, 0, 4'd0, 0, 0); tick("tight_loop");

    idle(); jump_en = 1; target = 8'h07;
    expect_state(8'h07, 0, 4'd0, 0, 0); tick("jump7");
    idle(); opcode = 4'hF; jump_en = 1; target = 8'h33;
    expect_state(8'h07, 1, 4'd0, 0, 0); tick("halt");
    idle(); call_en = 1; target = 8'h44;
    expect_state(8'h07, 1, 4'd0, 0, 0); tick("halt_frozen");

    // Nine nested calls against an 8-deep stack.
    do_reset("reset3");
    for (int i = 0; i < 8; i++) begin
      idle(); call_en = 1; target = 8'(8'h30 + 8 * i);
      expect_state(8'(8'h30 + 8 * i), 0, 4'(i + 1), 0, 0); tick("nest_call");
    end
    idle(); call_en = 1; target = 8'hA0;
    expect_state(8'h68, 1, 4'd8, 1, 0); tick("overflow");
    idle(); ret_en = 1;
    expect_state(8'h68, 1, 4'd8, 1, 0); tick("ovf_frozen");

    do_reset("reset4");
    idle(); ret_en = 1;
    expect_state(8'h00, 1, 4'd0, 0, 1); tick("underflow");
    #2;
    do_reset("async_reset");

    // Call at max pc pushes the wrapped return address 0.
    idle(); jump_en = 1; target = 8'hFF;
    expect_state(8'hFF, 0, 4'd0, 0, 0); tick("jumpFF");
    idle(); call_en = 1; target = 8'h05;
    expect_state(8'h05, 0, 4'd1, 0, 0); tick("call_at_max");
    idle(); ret_en = 1;
    expect_state(8'h00, 0, 4'd0, 0, 0); tick("ret_wrap0");
    idle(); jump_en = 1; target = 8'hFF;
    expect_state(8'hFF, 0, 4'd0, 0, 0); tick("jumpFF2");
    idle();
    expect_state(8'hFF, 1, 4'd0, 0, 0); tick("pc_overrun");
    idle();
    expect_state(8'hFF, 1, 4'd0, 0, 0); tick("overrun_held");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
